// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared states, defaults and widths for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;
    localparam int LAT_MIN     = 1;
    localparam int LAT_MAX     = 15;
    localparam int CNT_W       = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request bus between the CPU MEM stage and the responder.
interface data_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    modport master (output req_i, we_i, addr_i, wdata_i, input ready_o, ack_o, rdata_o, err_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, output ready_o, ack_o, rdata_o, err_o);
endinterface

// File: rtl/data_mem_responder_array.sv
// dmem_array: DEPTH x 32 storage, synchronous write, read register loaded on each commit.
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmt,
    input  logic                     i_wr,
    input  logic                     i_ld,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk)
        if (i_wr) r_mem[i_idx] <= i_wdata;

    // Stores and errored accesses leave zero in the read register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_rdata <= '0;
        else if (i_cmt) r_rdata <= i_ld ? r_mem[i_idx] : '0;

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder with fixed LATENCY-cycle completion.
// Define DMEM_ERR_EN to flag misaligned or out-of-range accesses instead of wrapping.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_we;
    logic [31:0]      r_addr, r_wdata;
    logic             w_accept, w_commit, w_cmt_we, w_err;
    logic [31:0]      w_cmt_addr, w_cmt_wdata;

    assign bus.ready_o = r_state != BUSY;
    assign bus.ack_o   = r_state == RESP;
    assign w_accept    = bus.req_i && bus.ready_o;
    // A single-cycle latency commits on the accepting edge, straight from the bus
    assign w_cmt_we    = LATENCY == 1 ? bus.we_i : r_we;
    assign w_cmt_addr  = LATENCY == 1 ? bus.addr_i : r_addr;
    assign w_cmt_wdata = LATENCY == 1 ? bus.wdata_i : r_wdata;
    assign w_commit    = (r_state == BUSY && r_cnt == CNT_W'(1)) || (LATENCY == 1 && w_accept);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        if (r_state == BUSY) begin
            w_cnt   = r_cnt - CNT_W'(1);
            w_state = r_cnt == CNT_W'(1) ? RESP : BUSY;
        end else if (w_accept) begin
            w_cnt   = CNT_W'(LATENCY - 1);
            w_state = LATENCY > 1 ? BUSY : RESP;
        end else begin
            w_state = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            if (w_accept) begin
                r_we    <= bus.we_i;
                r_addr  <= bus.addr_i;
                r_wdata <= bus.wdata_i;
            end
        end

`ifdef DMEM_ERR_EN
    logic r_err;
    assign w_err = w_cmt_addr[1:0] != 2'b00 || w_cmt_addr >= 32'(DEPTH * 4);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) r_err <= 1'b0;
        else if (w_commit) r_err <= w_err;
    assign bus.err_o = r_err;
`else
    logic w_unused;
    assign w_err     = 1'b0;
    assign w_unused  = ^{w_cmt_addr[31:AW+2], w_cmt_addr[1:0]};
    assign bus.err_o = 1'b0;
`endif

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_cmt   (w_commit),
        .i_wr    (w_commit && w_cmt_we && !w_err),
        .i_ld    (!w_cmt_we && !w_err),
        .i_idx   (w_cmt_addr[AW+1:2]),
        .i_wdata (w_cmt_wdata),
        .o_rdata (bus.rdata_o)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed load/store sequences checked against a transaction-level model.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic bad(input logic [31:0] a);
        return ERR_EN && ((a % 4) != 0 || a >= DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Transaction model: an access accepted at edge e commits at edge e+LAT-1,
    // acks in the following cycle, and the next request can be taken at edge e+LAT.
    int          edge_n, busy_until, cmt_edge, ack_edge;
    logic        pend, p_we, exp_err;
    logic [31:0] p_addr, p_wdata, exp_rdata;
    logic [31:0] mem_m [DEPTH];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            edge_n     <= 0;
            busy_until <= 0;
            cmt_edge   <= -1;
            ack_edge   <= -1;
            pend       <= 1'b0;
            exp_rdata  <= '0;
            exp_err    <= 1'b0;
        end else begin
            edge_n <= edge_n + 1;
            if (pend && cmt_edge == edge_n + 1) begin
                pend      <= 1'b0;
                ack_edge  <= edge_n + 1;
                exp_err   <= bad(p_addr);
                exp_rdata <= (p_we || bad(p_addr)) ? 32'h0 : mem_m[widx(p_addr)];
                if (p_we && !bad(p_addr)) mem_m[widx(p_addr)] <= p_wdata;
            end
            if (bus.req_i && edge_n + 1 >= busy_until) begin
                pend       <= 1'b1;
                p_we       <= bus.we_i;
                p_addr     <= bus.addr_i;
                p_wdata    <= bus.wdata_i;
                cmt_edge   <= edge_n + LAT;
                busy_until <= edge_n + 1 + LAT;
            end
        end

    always @(negedge clk) begin
        check("ready_o", bus.ready_o, edge_n + 1 >= busy_until);
        check("ack_o", bus.ack_o, edge_n == ack_edge);
        check("rdata_o", bus.rdata_o, exp_rdata);
        check("err_o", bus.err_o, exp_err);
    end

    int          cyc = 0;
    logic [31:0] ack_d [$];
    int          ack_c [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (bus.ack_o) begin
            ack_d.push_back(bus.rdata_o);
            ack_c.push_back(cyc);
        end

    task automatic send(input logic we, input logic [31:0] a, d, input logic hold);
        logic ok = 1'b0;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = a;
        bus.wdata_i = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ready_o;
            @(posedge clk);
        end
        check("accept", ok, 1'b1);
        #1;
        if (!hold) begin
            bus.req_i   = 1'b0;
            bus.we_i    = ~we;
            bus.addr_i  = '1;
            bus.wdata_i = 32'hBAD0BAD0;
        end
    endtask

    task automatic xfer(input string nm, input logic we, input logic [31:0] a, d, exp_d, input logic exp_e);
        int          lat = 0;
        logic [31:0] r = '0;
        logic        e = 1'b0;
        @(posedge clk);
        #1;
        send(we, a, d, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ack_o) begin
                lat = i;
                r   = bus.rdata_o;
                e   = bus.err_o;
                break;
            end
        end
        check({nm, " latency"}, lat, LAT);
        check({nm, " rdata"}, r, exp_d);
        check({nm, " err"}, e, exp_e);
    endtask

    initial begin
        int n0;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle ready", bus.ready_o, 1'b1);
            check("idle ack", bus.ack_o, 1'b0);
            check("idle rdata", bus.rdata_o, 32'h0);
        end

        xfer("store 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("load 0x10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_ERR_EN
        xfer("store 0x4", 1'b1, 32'h4, 32'h0BADF00D, 32'h0, 1'b0);
        xfer("store 0x6", 1'b1, 32'h6, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer("load 0x4", 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1'b0);
        xfer("load 0x400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
`else
        xfer("store 0x400", 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0);
        xfer("load wrap 0x0", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
`endif

        // Back-to-back with req held: each new request is taken in RESP
        @(posedge clk);
        #1;
        n0 = ack_d.size();
        send(1'b1, 32'h0, 32'hCAFE0001, 1'b1);
        send(1'b0, 32'h0, 32'h0, 1'b1);
        send(1'b1, 32'h4, 32'hCAFE0002, 1'b1);
        send(1'b0, 32'h4, 32'h0, 1'b0);
        for (int i = 0; i < 20 && ack_d.size() < n0 + 4; i++) @(negedge clk);
        check("b2b ack count", ack_d.size() - n0, 4);
        if (ack_d.size() >= n0 + 4) begin
            check("b2b store ack rdata", ack_d[n0], 32'h0);
            check("b2b load 0x0", ack_d[n0+1], 32'hCAFE0001);
            check("b2b load 0x4", ack_d[n0+3], 32'hCAFE0002);
            for (int k = 1; k < 4; k++) check("b2b ack spacing", ack_c[n0+k] - ack_c[n0+k-1], LAT);
        end

        // Reset during BUSY drops the store before its commit edge
        xfer("store 0x20", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        n0 = ack_d.size();
        send(1'b1, 32'h20, 32'h12345678, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset drops ack", ack_d.size() - n0, 0);
        xfer("load 0x20 after reset", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
